// File: rtl/rob_tag_ctrl_if.sv
// Dispatch / CDB / retire handshake bundle for the ROB tag controller.
// The slave side is the controller, the master side is the surrounding pipeline.
interface rob_tag_ctrl_if #(
    parameter int TAG_W = 6
);
    logic             alloc_req;
    logic             alloc_gnt;
    logic [TAG_W-1:0] alloc_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic             commit_stall;
    logic             commit_en;
    logic [TAG_W-1:0] commit_tag;
    logic             flush;
    logic             rob_full;
    logic             rob_empty;
    logic [TAG_W:0]   rob_count;

    modport master (
        output alloc_req, cdb_valid, cdb_tag, commit_stall, flush,
        input  alloc_gnt, alloc_tag, commit_en, commit_tag,
               rob_full, rob_empty, rob_count
    );

    modport slave (
        input  alloc_req, cdb_valid, cdb_tag, commit_stall, flush,
        output alloc_gnt, alloc_tag, commit_en, commit_tag,
               rob_full, rob_empty, rob_count
    );
endinterface

// File: rtl/rob_tag_ctrl.sv
// Reorder-buffer tag controller: circular head/tail allocator with per-entry
// busy/done tracking, CDB completion marking, in-order retire and flush.

module rob_tag_entry (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic alloc_i,
    input  logic cdb_i,
    input  logic commit_i,
    output logic busy_o,
    output logic done_o
);
    logic busy_q, busy_d;
    logic done_q, done_d;

    // Commit is applied last so a redundant CDB hit on the retiring head
    // cannot leave a stale done bit behind.
    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        if (flush_i) begin
            busy_d = 1'b0;
            done_d = 1'b0;
        end else begin
            if (alloc_i) begin
                busy_d = 1'b1;
                done_d = 1'b0;
            end
            if (cdb_i) begin
                done_d = 1'b1;
            end
            if (commit_i) begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

module rob_tag_ctrl #(
    parameter int DEPTH = 64,
    parameter int TAG_W = 6
) (
    input  logic         clk,
    input  logic         i_rst_n,
    rob_tag_ctrl_if.slave bus
);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] alloc_sel;
    logic [DEPTH-1:0] cdb_hit;
    logic [DEPTH-1:0] commit_sel;

    logic full;
    logic empty;
    logic gnt;
    logic cmt;

    // Status comes from the registered count only, never from this cycle's
    // commit, so a full ROB cannot be refilled in the cycle it drains.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign gnt   = bus.alloc_req & ~full & ~bus.flush;
    assign cmt   = ~empty & done[head_q] & ~bus.commit_stall & ~bus.flush;

    assign bus.alloc_gnt  = gnt;
    assign bus.alloc_tag  = tail_q;
    assign bus.commit_en  = cmt;
    assign bus.commit_tag = head_q;
    assign bus.rob_full   = full;
    assign bus.rob_empty  = empty;
    assign bus.rob_count  = count_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign alloc_sel[i]  = gnt & (tail_q == TAG_W'(i));
        assign cdb_hit[i]    = bus.cdb_valid & ~bus.flush & busy[i] &
                               (bus.cdb_tag == TAG_W'(i));
        assign commit_sel[i] = cmt & (head_q == TAG_W'(i));

        rob_tag_entry u_entry (
            .clk      (clk),
            .rst_n    (i_rst_n),
            .flush_i  (bus.flush),
            .alloc_i  (alloc_sel[i]),
            .cdb_i    (cdb_hit[i]),
            .commit_i (commit_sel[i]),
            .busy_o   (busy[i]),
            .done_o   (done[i])
        );
    end

    // Pointers wrap naturally at TAG_W bits since DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (gnt) tail_d = tail_q + 1'b1;
            if (cmt) head_d = head_q + 1'b1;
            unique case ({gnt, cmt})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_rob_tag_ctrl.sv
// Directed scenarios plus a randomized run against a queue-based ROB model.
module tb_rob_tag_ctrl;
    localparam int DEPTH = 64;
    localparam int TAG_W = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rob_tag_ctrl_if #(.TAG_W(TAG_W)) bus();

    rob_tag_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic drive(input logic a, input logic cv, input int ct,
                         input logic st, input logic fl);
        bus.alloc_req    = a;
        bus.cdb_valid    = cv;
        bus.cdb_tag      = TAG_W'(ct);
        bus.commit_stall = st;
        bus.flush        = fl;
        #1;
    endtask

    task automatic next_cycle;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({bus.alloc_gnt, bus.alloc_tag, bus.commit_en, bus.commit_tag,
             bus.rob_count, bus.rob_empty, bus.rob_full} !==
            {1'b1, 6'd0, 1'b0, 6'd0, 7'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: gnt=%b atag=%0d cen=%b ctag=%0d cnt=%0d emp=%b full=%b want 1 0 0 0 0 1 0",
                     bus.alloc_gnt, bus.alloc_tag, bus.commit_en, bus.commit_tag,
                     bus.rob_count, bus.rob_empty, bus.rob_full);
        end
        drive(0, 0, 0, 0, 0);
        vectors++;
        if (bus.alloc_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_gnt_follows_req: got %b want 0", bus.alloc_gnt);
        end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_alloc3;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0);
            vectors++;
            if ({bus.alloc_gnt, bus.alloc_tag, bus.commit_en} !== {1'b1, TAG_W'(k), 1'b0}) begin
                miscompares++;
                $display("FAIL alloc3[%0d]: gnt=%b tag=%0d cen=%b want 1 %0d 0",
                         k, bus.alloc_gnt, bus.alloc_tag, bus.commit_en, k);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0);
        vectors++;
        if ({bus.rob_count, bus.commit_en, bus.rob_empty} !== {7'd3, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL alloc3_count: cnt=%0d cen=%b emp=%b want 3 0 0",
                     bus.rob_count, bus.commit_en, bus.rob_empty);
        end
    endtask

    task automatic test_cdb_order;
        logic [6:0] exp_seq [5];
        exp_seq[0] = {1'b1, 6'd0};
        exp_seq[1] = {1'b1, 6'd1};
        exp_seq[2] = {1'b0, 6'd2};
        exp_seq[3] = {1'b0, 6'd2};
        exp_seq[4] = {1'b0, 6'd2};
        drive(0, 1, 1, 0, 0);
        vectors++;
        if (bus.commit_en !== 1'b0) begin
            miscompares++;
            $display("FAIL cdb_tag1_no_commit: cen=%b want 0", bus.commit_en);
        end
        next_cycle();
        drive(0, 1, 0, 0, 0);
        vectors++;
        if (bus.commit_en !== 1'b0) begin
            miscompares++;
            $display("FAIL cdb_no_bypass: cen=%b want 0", bus.commit_en);
        end
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 0);
            vectors++;
            if ({bus.commit_en, bus.commit_tag} !== exp_seq[k]) begin
                miscompares++;
                $display("FAIL cdb_retire_seq[%0d]: cen=%b ctag=%0d want %b %0d",
                         k, bus.commit_en, bus.commit_tag, exp_seq[k][6], exp_seq[k][5:0]);
            end
            next_cycle();
        end
        drive(0, 1, 2, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        vectors++;
        if ({bus.commit_en, bus.commit_tag} !== {1'b1, 6'd2}) begin
            miscompares++;
            $display("FAIL cdb_tag2_commit: cen=%b ctag=%0d want 1 2", bus.commit_en, bus.commit_tag);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        vectors++;
        if ({bus.rob_empty, bus.rob_count, bus.commit_en} !== {1'b1, 7'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL cdb_drained: emp=%b cnt=%0d cen=%b want 1 0 0",
                     bus.rob_empty, bus.rob_count, bus.commit_en);
        end
    endtask

    task automatic test_full_wrap;
        drive(0, 0, 0, 0, 1);
        next_cycle();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 0, 0, 0, 0);
            vectors++;
            if ({bus.alloc_gnt, bus.alloc_tag} !== {1'b1, TAG_W'(k)}) begin
                miscompares++;
                $display("FAIL fill[%0d]: gnt=%b tag=%0d want 1 %0d", k, bus.alloc_gnt, bus.alloc_tag, k);
            end
            next_cycle();
        end
        drive(1, 0, 0, 0, 0);
        vectors++;
        if ({bus.rob_full, bus.alloc_gnt, bus.rob_count} !== {1'b1, 1'b0, 7'd64}) begin
            miscompares++;
            $display("FAIL full_block: full=%b gnt=%b cnt=%0d want 1 0 64",
                     bus.rob_full, bus.alloc_gnt, bus.rob_count);
        end
        next_cycle();
        drive(1, 1, 0, 0, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0);
        vectors++;
        if ({bus.commit_en, bus.commit_tag, bus.alloc_gnt} !== {1'b1, 6'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL full_no_bypass: cen=%b ctag=%0d gnt=%b want 1 0 0",
                     bus.commit_en, bus.commit_tag, bus.alloc_gnt);
        end
        next_cycle();
        drive(1, 0, 0, 0, 0);
        vectors++;
        if ({bus.alloc_gnt, bus.alloc_tag, bus.commit_en, bus.rob_full, bus.rob_count} !==
            {1'b1, 6'd0, 1'b0, 1'b0, 7'd63}) begin
            miscompares++;
            $display("FAIL wrap_grant: gnt=%b tag=%0d cen=%b full=%b cnt=%0d want 1 0 0 0 63",
                     bus.alloc_gnt, bus.alloc_tag, bus.commit_en, bus.rob_full, bus.rob_count);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        vectors++;
        if ({bus.rob_full, bus.rob_count, bus.commit_tag} !== {1'b1, 7'd64, 6'd1}) begin
            miscompares++;
            $display("FAIL refill: full=%b cnt=%0d ctag=%0d want 1 64 1",
                     bus.rob_full, bus.rob_count, bus.commit_tag);
        end
        drive(0, 0, 0, 0, 1);
        next_cycle();
    endtask

    task automatic test_cdb_idle;
        drive(0, 1, 10, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        vectors++;
        if ({bus.rob_count, bus.rob_empty, bus.alloc_tag} !== {7'd0, 1'b1, 6'd0}) begin
            miscompares++;
            $display("FAIL idle_cdb_state: cnt=%0d emp=%b atag=%0d want 0 1 0",
                     bus.rob_count, bus.rob_empty, bus.alloc_tag);
        end
        for (int k = 0; k <= 10; k++) begin
            drive(1, 0, 0, 1, 0);
            next_cycle();
        end
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, k, 1, 0);
            next_cycle();
        end
        for (int k = 0; k < 12; k++) begin
            drive(0, 0, 0, 0, 0);
            vectors++;
            if ({bus.commit_en, bus.commit_tag} !== {(k < 10), TAG_W'((k < 10) ? k : 10)}) begin
                miscompares++;
                $display("FAIL idle_cdb_retire[%0d]: cen=%b ctag=%0d want %0d %0d",
                         k, bus.commit_en, bus.commit_tag, (k < 10), (k < 10) ? k : 10);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 1);
        next_cycle();
    endtask

    task automatic test_flush;
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0, 0);
            next_cycle();
        end
        drive(0, 1, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        vectors++;
        if (bus.commit_en !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_pre_head_done: cen=%b want 1", bus.commit_en);
        end
        drive(1, 0, 0, 0, 1);
        vectors++;
        if ({bus.commit_en, bus.alloc_gnt} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_cycle: cen=%b gnt=%b want 0 0", bus.commit_en, bus.alloc_gnt);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        vectors++;
        if ({bus.rob_count, bus.alloc_tag, bus.commit_tag, bus.rob_empty} !==
            {7'd0, 6'd0, 6'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL flush_after: cnt=%0d atag=%0d ctag=%0d emp=%b want 0 0 0 1",
                     bus.rob_count, bus.alloc_tag, bus.commit_tag, bus.rob_empty);
        end
    endtask

    task automatic test_stall;
        drive(1, 0, 0, 0, 0);
        next_cycle();
        drive(0, 1, 0, 1, 0);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 0);
            vectors++;
            if ({bus.commit_en, bus.commit_tag} !== {1'b0, 6'd0}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: cen=%b ctag=%0d want 0 0", k, bus.commit_en, bus.commit_tag);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0);
        vectors++;
        if ({bus.commit_en, bus.commit_tag} !== {1'b1, 6'd0}) begin
            miscompares++;
            $display("FAIL stall_release: cen=%b ctag=%0d want 1 0", bus.commit_en, bus.commit_tag);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        vectors++;
        if ({bus.rob_empty, bus.commit_tag} !== {1'b1, 6'd1}) begin
            miscompares++;
            $display("FAIL stall_after: emp=%b ctag=%0d want 1 1", bus.rob_empty, bus.commit_tag);
        end
    endtask

    task automatic test_mid_reset;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0);
            next_cycle();
        end
        drive(0, 1, 1, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        vectors++;
        if ({bus.commit_en, bus.commit_tag} !== {1'b1, 6'd1}) begin
            miscompares++;
            $display("FAIL midrst_pre: cen=%b ctag=%0d want 1 1", bus.commit_en, bus.commit_tag);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.commit_en, bus.rob_count, bus.rob_empty, bus.commit_tag, bus.alloc_tag} !==
            {1'b0, 7'd0, 1'b1, 6'd0, 6'd0}) begin
            miscompares++;
            $display("FAIL midrst_discard: cen=%b cnt=%0d emp=%b ctag=%0d atag=%0d want 0 0 1 0 0",
                     bus.commit_en, bus.rob_count, bus.rob_empty, bus.commit_tag, bus.alloc_tag);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_random;
        int   q[$];
        bit   mdone[DEPTH];
        int   ntag;
        logic a, cv, st, fl;
        int   ct;
        bit   in_q;
        bit   e_full, e_gnt, e_en;
        int   e_ctag;
        logic [22:0] got, want;

        drive(0, 0, 0, 0, 1);
        next_cycle();
        foreach (mdone[i]) mdone[i] = 1'b0;
        ntag = 0;
        for (int n = 0; n < 3000; n++) begin
            a  = ($urandom % 10) < 7;
            fl = ($urandom % 60) == 0;
            st = ((n / 400) % 2 == 1) ? (($urandom % 10) < 8) : (($urandom % 5) == 0);
            cv = ($urandom % 10) < 6;
            if (q.size() > 0 && ($urandom % 4) != 0) ct = q[$urandom % q.size()];
            else ct = int'($urandom % DEPTH);
            drive(a, cv, ct, st, fl);

            e_full = (q.size() == DEPTH);
            e_gnt  = a && !e_full && !fl;
            e_en   = (q.size() > 0) && mdone[q[0]] && !st && !fl;
            e_ctag = (q.size() > 0) ? q[0] : ntag;
            want = {e_gnt, TAG_W'(ntag), e_en, TAG_W'(e_ctag), (TAG_W+1)'(q.size()),
                    (q.size() == 0), e_full};
            got  = {bus.alloc_gnt, bus.alloc_tag, bus.commit_en, bus.commit_tag,
                    bus.rob_count, bus.rob_empty, bus.rob_full};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL random[%0d]: got gnt/atag/cen/ctag/cnt/emp/full=%h want %h", n, got, want);
            end

            if (fl) begin
                q.delete();
                foreach (mdone[i]) mdone[i] = 1'b0;
                ntag = 0;
            end else begin
                in_q = 1'b0;
                foreach (q[i]) if (q[i] == ct) in_q = 1'b1;
                if (cv && in_q) mdone[ct] = 1'b1;
                if (e_en) begin
                    mdone[q[0]] = 1'b0;
                    void'(q.pop_front());
                end
                if (e_gnt) begin
                    q.push_back(ntag);
                    mdone[ntag] = 1'b0;
                    ntag = (ntag + 1) % DEPTH;
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_alloc3();
        test_cdb_order();
        test_full_wrap();
        test_cdb_idle();
        test_flush();
        test_stall();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach summary, want completion");
        $fatal(1);
    end
endmodule

// File: doc/rob_tag_ctrl.md
ROB_TAG_CTRL -- requirements
Module: rob_tag_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of ROB entries (power of two).
REQ-002 SHALL have parameter TAG_W, default 6, tag width, log2(DEPTH).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port alloc_req  input  1  dispatch requests one ROB entry.
REQ-007 SHALL have port alloc_gnt  output  1  allocation accepted this cycle.
REQ-008 SHALL have port alloc_tag  output  TAG_W  tag of entry being allocated (tail pointer).
REQ-009 SHALL have port cdb_valid  input  1  CDB broadcast valid.
REQ-010 SHALL have port cdb_tag  input  TAG_W  ROB tag of broadcast result.
REQ-011 SHALL have port commit_stall  input  1  retire stage cannot accept a commit.
REQ-012 SHALL have port commit_en  output  1  head entry retires this cycle.
REQ-013 SHALL have port commit_tag  output  TAG_W  tag of head entry (read address for ROB file).
REQ-014 SHALL have port flush  input  1  synchronous pipeline flush (mispredict).
REQ-015 SHALL have port rob_full  output  1  count == DEPTH.
REQ-016 SHALL have port rob_empty  output  1  count == 0.
REQ-017 SHALL have port rob_count  output  TAG_W+1  occupied entries, 0..DEPTH.

Function
REQ-018 SHALL hold state: head, tail (TAG_W bits each), count (TAG_W+1 bits), per-entry busy[DEPTH] and done[DEPTH] bits.
REQ-019 SHALL drive alloc_gnt = alloc_req & !rob_full & !flush, combinationally.
REQ-020 SHALL drive alloc_tag = tail at all times, regardless of alloc_req.
REQ-021 SHALL, on a clock edge with alloc_gnt, set busy[tail]=1, done[tail]=0, tail=tail+1 modulo DEPTH (63 wraps to 0).
REQ-022 SHALL, on a clock edge with cdb_valid & !flush & busy[cdb_tag], set done[cdb_tag]=1.
REQ-023 SHALL ignore CDB broadcasts to entries with busy=0 (no state change).
REQ-024 SHALL drive commit_en = !rob_empty & done[head] & !commit_stall & !flush, combinationally.
REQ-025 SHALL drive commit_tag = head at all times.
REQ-026 SHALL, on a clock edge with commit_en, clear busy[head] and done[head] and set head=head+1 modulo DEPTH.
REQ-027 SHALL NOT bypass a same-cycle CDB into commit_en: a CDB hit on the head entry produces commit_en no earlier than the following cycle.
REQ-028 SHALL update count by +1 on alloc only, -1 on commit only, unchanged on both or neither.
REQ-029 SHALL block allocation when full even if commit_en is asserted in the same cycle (no full-bypass).
REQ-030 SHALL allow alloc and commit in the same cycle when 0 < count < DEPTH.
REQ-031 SHALL, on a clock edge with flush=1, set head=0, tail=0, count=0, clear all busy and done bits; flush has priority over alloc, CDB and commit.
REQ-032 SHALL derive rob_full, rob_empty and rob_count from registered count only.

Reset
REQ-033 SHALL, while i_rst_n=0, asynchronously force head=0, tail=0, count=0 and all busy/done bits to 0.
REQ-034 SHALL present after reset: alloc_tag=0, commit_tag=0, rob_count=0, rob_empty=1, rob_full=0, commit_en=0, and alloc_gnt=alloc_req.
REQ-035 SHALL, on reset assertion mid-operation, discard all in-flight entries with no commit_en pulse in that cycle.

Verification
REQ-036 SHALL pass: reset, alloc_req=1 for 3 cycles -> alloc_tag 0,1,2 granted, rob_count=3, commit_en=0.
REQ-037 SHALL pass: entries 0..2 allocated, CDB tag 1 then tag 0 -> commit_en is asserted the cycle after tag 0 arrives, retires tags 0,1 on consecutive cycles, then stays 0 until tag 2 completes.
REQ-038 SHALL pass: 64 allocations -> rob_full=1, alloc_gnt=0 while alloc_req=1; with head done and alloc_req held, commit in cycle N is followed by grant of tag 0 (wrapped) in N+1.
REQ-039 SHALL pass: CDB tag 10 when busy[10]=0 -> no state change, later alloc of tag 10 shows done=0.
REQ-040 SHALL pass: 5 entries in flight, head done, flush=1 -> commit_en=0 that cycle, next cycle rob_count=0, alloc_tag=0, commit_tag=0, rob_empty=1.
REQ-041 SHALL pass: head done with commit_stall=1 for 4 cycles -> commit_en=0, head held; commit on the first cycle with commit_stall=0.
